// File: rtl/ysyx_24100029_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring division, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at issue and bypass the iteration.
module ysyx_24100029_div #(
  parameter int unsigned BW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  input  logic [1:0]    op,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] result,
  output logic          busy
);

  localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [BW-1:0] MIN_NEG = {1'b1, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [1:0]    op_r;
  logic          neg_a;
  logic          neg_b;
  logic [BW-1:0] rem;
  logic [BW-1:0] quo;
  logic [BW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic          in_signed;
  logic          a_neg;
  logic          b_neg;
  logic [BW-1:0] abs_a;
  logic [BW-1:0] abs_b;
  logic          div_zero;
  logic          ovf;
  logic [BW-1:0] special_res;
  logic [BW:0]   rem_sh;
  logic          ge;
  logic [BW-1:0] rem_n;
  logic [BW-1:0] quo_n;
  logic [BW-1:0] quo_fix;
  logic [BW-1:0] rem_fix;
  logic [BW-1:0] final_res;

  // Issue-side decode: operand magnitudes and the early-completion cases
  always_comb begin
    in_signed   = ~op[0];
    a_neg       = in_signed & dividend[BW-1];
    b_neg       = in_signed & divisor[BW-1];
    abs_a       = a_neg ? -dividend : dividend;
    abs_b       = b_neg ? -divisor : divisor;
    div_zero    = (divisor == '0);
    ovf         = in_signed && (dividend == MIN_NEG) && (divisor == '1);
    special_res = '0;
    if (div_zero) special_res = op[1] ? dividend : '1;
    else          special_res = op[1] ? '0 : MIN_NEG;
  end

  // One restoring step; the shifted remainder carries an extra top bit for the compare
  always_comb begin
    rem_sh    = {rem, quo[BW-1]};
    ge        = (rem_sh >= {1'b0, dvs});
    rem_n     = ge ? BW'(rem_sh - {1'b0, dvs}) : rem_sh[BW-1:0];
    quo_n     = {quo[BW-2:0], ge};
    quo_fix   = (~op_r[0] & (neg_a ^ neg_b)) ? -quo_n : quo_n;
    rem_fix   = (~op_r[0] & neg_a) ? -rem_n : rem_n;
    final_res = op_r[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r  <= op;
            neg_a <= a_neg;
            neg_b <= b_neg;
            cnt   <= CW'(BW - 1);
            if (div_zero || ovf) begin
              result <= special_res;
              state  <= DONE;
            end else begin
              rem   <= '0;
              quo   <= abs_a;
              dvs   <= abs_b;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          if (cnt == '0) begin
            result <= final_res;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ysyx_24100029_div.sv
// Self-checking bench for ysyx_24100029_div: vector table plus handshake/flush/reset sequences.
module tb_ysyx_24100029_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [1:0]  op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  ysyx_24100029_div #(.BW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .op(op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one op in a single cycle; returns #1 after the accept edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycles counted inclusively from the accept edge until out_valid is seen
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int seen;

    vecs[0]  = '{2'b00, 32'd100,        32'd7,        32'h0000000E, 33};
    vecs[1]  = '{2'b10, 32'd100,        32'd7,        32'h00000002, 33};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF,   32'd2,        32'h7FFFFFFF, 33};
    vecs[3]  = '{2'b00, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
    vecs[4]  = '{2'b10, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
    vecs[5]  = '{2'b11, 32'd7,          32'hFFFFFFFF, 32'h00000007, 33};
    vecs[6]  = '{2'b00, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[7]  = '{2'b10, 32'd7,          32'hFFFFFFFE, 32'h00000001, 33};
    vecs[8]  = '{2'b00, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{2'b11, 32'd5,          32'd0,        32'h00000005, 1};
    vecs[10] = '{2'b01, 32'd0,          32'd0,        32'hFFFFFFFF, 1};
    vecs[11] = '{2'b00, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[12] = '{2'b10, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1};

    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; op = '0;
    flush = 1'b0; out_ready = 1'b1;
    #23;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(cyc);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
      @(posedge clk); #1;
      check($sformatf("vec%0d_ready_after", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result held for 10 cycles, then immediate reissue
    out_ready = 1'b0;
    issue(2'b00, 32'd100, 32'd7);
    wait_valid(cyc);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, 30'd0} | (result & 32'h3FFFFFFF),
            {1'b1, 1'b0, 30'd0} | 32'h0000000E);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after_hs", 32'(in_ready), 32'd1);
    issue(2'b11, 32'd7, 32'd0);
    check("bp_reissue_valid", 32'(out_valid), 32'd1);
    check("bp_reissue_result", result, 32'd7);
    @(posedge clk); #1;

    // Flush on the 10th CALC cycle
    issue(2'b00, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc_ready", 32'(in_ready), 32'd1);
    check("flush_calc_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("flush_calc_never_valid", 32'(seen), 32'd0);
    check("flush_calc_result_held", result, 32'd7);

    // Flush coincident with a special-case issue in IDLE
    @(negedge clk);
    op = 2'b00; dividend = 32'd5; divisor = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", 32'(in_ready), 32'd1);
    check("flush_idle_valid", 32'(out_valid), 32'd0);
    check("flush_idle_result", result, 32'd7);

    // Flush in DONE beats the output handshake
    out_ready = 1'b0;
    issue(2'b00, 32'd5, 32'd0);
    check("flush_done_valid_pre", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done_valid", 32'(out_valid), 32'd0);
    check("flush_done_ready", 32'(in_ready), 32'd1);
    check("flush_done_result_held", result, 32'hFFFFFFFF);

    // Asynchronous reset mid-CALC, then a clean operation
    issue(2'b00, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b00, 32'd100, 32'd7);
    wait_valid(cyc);
    check("post_rst_result", result, 32'h0000000E);
    check("post_rst_latency", 32'(cyc), 32'd33);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_div.md
# ysyx_24100029_div

Iterative RV32M divide/remainder unit sitting beside the single-cycle ALU in the execute stage. It performs DIV, DIVU, REM and REMU by restoring division, one quotient bit per cycle. It uses a valid/ready handshake on both sides so the pipeline stalls while it is busy. Divide-by-zero and signed overflow are detected at issue and complete early with RISC-V-mandated results.

## Interface
- BW, default 32: operand/result width.
- clk  in  1: clock; all state changes on the rising edge.
- rst  in  1: reset, asynchronous, active-high.
- in_valid  in  1: operands and op are valid.
- in_ready  out  1: unit can accept; equals (state == IDLE).
- dividend  in  BW: rs1 value.
- divisor  in  BW: rs2 value.
- op  in  2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- flush  in  1: synchronous kill of any in-flight operation (branch mispredict/trap).
- out_valid  out  1: result is valid; equals (state == DONE).
- out_ready  in  1: consumer takes the result.
- result  out  BW: registered quotient or remainder.
- busy  out  1: high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC on accept (in_valid && in_ready && !flush), unless a special case applies.
- IDLE -> DONE on accept when a special case applies.
- CALC -> DONE after exactly BW iteration cycles.
- DONE -> IDLE on out_valid && out_ready.
- Any state -> IDLE on flush; flush beats a same-cycle accept and a same-cycle output handshake (result is lost, no accept occurs).
- On accept, latch the op, the operand signs, |dividend| and |divisor| (absolute values only for DIV/REM; raw values for DIVU/REMU), and load the counter with BW-1.
- Iteration:
  - rem = {rem[BW-1:0], q[BW-1]}; q <<= 1.
  - If rem >= divisor: rem -= divisor, q[0] = 1.
  - rem is BW+1 bits wide; the comparison and subtraction are unsigned.
- Sign fix on entry to DONE, signed ops only:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the dividend sign.
  - Negation is two's complement, modulo 2^BW.
- Special cases, detected from the raw inputs at accept:
  - divisor == 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - DIV/REM with dividend == 2^(BW-1) and divisor == all ones: DIV gives 2^(BW-1); REM gives 0.
- result is loaded only on entry to DONE and holds its value until the next entry to DONE, including after the handshake and after a flush.
- Inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, result 0, counter 0.
- Reset asserted mid-operation aborts immediately and asynchronously; no result is produced.
- Normal latency: the accept edge is edge 0; CALC occupies edges 1..BW; out_valid rises after edge BW, i.e. BW+1 cycles after in_valid is sampled.
- Special-case latency: out_valid rises after edge 1.
- out_valid stays high with result stable while out_ready is low.
- out_valid is not combinationally dependent on out_ready.
- No back-to-back issue: in_ready is low in DONE; the earliest next accept is the edge after the output handshake.
- A flush in cycle n gives in_ready = 1 and out_valid = 0 after edge n.
- Zero combinational paths from inputs to outputs.

## Test plan
- Signed, unsigned and remainder results, BW = 32:
  - DIV 100/7 -> 0x0000000E after 33 cycles.
  - REM 100/7 -> 0x00000002.
  - DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - REMU 7/0xFFFFFFFF -> 7.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF, with out_valid after 1 cycle.
  - REMU 5/0 -> 0x00000005.
  - DIVU 0/0 -> 0xFFFFFFFF.
- Signed overflow:
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle.
  - REM with the same operands -> 0x00000000.
- Backpressure: hold out_ready low for 10 cycles after out_valid.
  - result and out_valid stay stable; in_ready stays 0.
  - After the handshake: in_ready = 1 the next cycle, and a new op is accepted there.
- Flush:
  - Flush on the 10th CALC cycle -> out_valid never rises and in_ready = 1 next cycle.
  - Flush coincident with in_valid in IDLE -> no accept.
  - Flush in DONE with out_ready = 1 -> no output handshake occurs.
- Reset: assert rst asynchronously mid-CALC.
  - Outputs return to their reset values immediately.
  - After release, DIV 100/7 completes correctly.
